// File: rtl/mem_pkg.sv
// mem_pkg: access-size and FSM types, lane widths and the load-extension helper for mem_stage_mc.
package mem_pkg;
  typedef enum logic [1:0] {MEM_B = 2'b00, MEM_H = 2'b01, MEM_W = 2'b10} mem_size_t;
  typedef enum logic {IDLE, WAIT} mem_state_t;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int LANES = 4;
  // v is already shifted so the addressed lane sits in the low bits; size 11 falls through as word
  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz, input logic sgn);
    return sz == MEM_B ? {{(32-BYTE_W){sgn & v[BYTE_W-1]}}, v[BYTE_W-1:0]}
         : sz == MEM_H ? {{(32-HALF_W){sgn & v[HALF_W-1]}}, v[HALF_W-1:0]} : v;
  endfunction
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: word-wide data RAM with per-byte write enable, synchronous write and asynchronous read.
module dmem_bank import mem_pkg::*; #(
  parameter int DMEM_POWER = 18
) (
  input  logic                  clk,
  input  logic [LANES-1:0]      be,
  input  logic [DMEM_POWER-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**DMEM_POWER];
  always_ff @(posedge clk)
    for (int i = 0; i < LANES; i++)
      if (be[i]) mem[addr][BYTE_W*i +: BYTE_W] <= wdata[BYTE_W*i +: BYTE_W];
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage_mc.sv
// mem_stage_mc: pipelined memory stage with byte/half/word access and LATENCY wait cycles per access.
// Defining MEM_MISALIGN_TRAP_EN adds the misalignW trap; otherwise low address bits are forced aligned.
module mem_stage_mc import mem_pkg::*; #(
  parameter int WORD       = 32,
  parameter int REG_SIZE   = 5,
  parameter int DMEM_POWER = 18,
  parameter int LATENCY    = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORD-1:0]     writeDataM,
  input  logic [WORD-1:0]     ALUResultM,
  input  logic [WORD-1:0]     pcM,
  input  logic [REG_SIZE-1:0] writeRegM,
  input  logic                regWriteM,
  input  logic                memWriteM,
  input  logic                mem2regM,
  input  logic [1:0]          memSizeM,
  input  logic                memSignedM,
  input  logic                zeroM,
  input  logic                branchM,
  input  logic                finishM,
  input  logic                validM,
  output logic [WORD-1:0]     readDataW,
  output logic [WORD-1:0]     ALUResultW,
  output logic [WORD-1:0]     pcW,
  output logic [REG_SIZE-1:0] writeRegW,
  output logic                regWriteW,
  output logic                mem2regW,
  output logic                memWriteW,
  output logic                finishW,
  output logic                validW,
  output logic                PCSrcM,
  output logic                stallM
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                misalignW
`endif
);
  localparam logic [3:0] LAT = 4'(LATENCY);
  mem_state_t state, state_n;
  logic [3:0] cnt, cnt_n, be;
  logic acc, mis, stall;
  logic [1:0] lane;
  logic [WORD-1:0] rdata, wdata, ldata;
  assign acc = validM & (memWriteM | mem2regM);
  assign lane = memSizeM == MEM_B ? ALUResultM[1:0] : memSizeM == MEM_H ? {ALUResultM[1], 1'b0} : 2'b00;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = acc & (memSizeM == MEM_H ? ALUResultM[0] : memSizeM != MEM_B && ALUResultM[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign be = memSizeM == MEM_B ? 4'b0001 << lane : memSizeM == MEM_H ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata = memSizeM == MEM_B ? {LANES{writeDataM[BYTE_W-1:0]}}
               : memSizeM == MEM_H ? {2{writeDataM[HALF_W-1:0]}} : writeDataM;
  assign ldata = extend(rdata >> {lane, 3'b000}, memSizeM, memSignedM);
  assign stallM = stall & reset;
  assign PCSrcM = zeroM & branchM & validM;
  // the store commits only on its completing cycle, and never while reset is held
  dmem_bank #(.DMEM_POWER(DMEM_POWER)) u_bank (
    .clk,
    .be(be & {LANES{memWriteM & acc & ~mis & ~stall & reset}}),
    .addr(ALUResultM[DMEM_POWER+1:2]),
    .wdata,
    .rdata
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    stall = 1'b0;
    if (state == IDLE) begin
      if (acc && !mis && LATENCY != 0) begin
        state_n = WAIT;
        cnt_n = 4'd1;
        stall = 1'b1;
      end
    end else if (cnt == LAT) begin
      state_n = IDLE;
      cnt_n = '0;
    end else begin
      cnt_n = cnt + 4'd1;
      stall = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      {readDataW, ALUResultW, pcW, writeRegW, regWriteW, mem2regW, memWriteW, finishW, validW} <= '0;
    else if (stall)
      {readDataW, ALUResultW, pcW, writeRegW, regWriteW, mem2regW, memWriteW, finishW, validW} <= '0;
    else begin
      readDataW <= mis ? '0 : ldata;
      ALUResultW <= ALUResultM;
      pcW <= pcM;
      writeRegW <= writeRegM;
      regWriteW <= regWriteM & ~mis;
      mem2regW <= mem2regM;
      memWriteW <= memWriteM;
      finishW <= finishM;
      validW <= validM;
    end
`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) misalignW <= 1'b0;
    else misalignW <= mis;
`endif
endmodule

// File: doc/mem_stage_mc.md
# mem_stage_mc

Parametrised successor to the single-cycle memory stage of the pipelined CPU. Sits between execute and writeback. Adds byte/half/word loads and stores with sign or zero extension, plus a configurable multi-cycle data-memory latency. While an access is in flight it stalls the upstream pipeline through a handshake and inserts bubbles into the M/W register.

## Interface
Parameters:
- `WORD`, 32: datapath width; must be 32.
- `REG_SIZE`, 5: register-index width.
- `DMEM_POWER`, 18: log2 of data-memory depth in words.
- `LATENCY`, 0: extra wait cycles per memory access; legal range 0..15.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `writeDataM`, `ALUResultM`, `pcM`  in  WORD  store data, address/ALU result, PC.
- `writeRegM`  in  REG_SIZE  destination register.
- `regWriteM`, `memWriteM`, `mem2regM`  in  1  control bits.
- `memSizeM`  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- `memSignedM`  in  1  1 = sign-extend loads, 0 = zero-extend.
- `zeroM`, `branchM`, `finishM`, `validM`  in  1  branch and status bits.
- `readDataW`, `ALUResultW`, `pcW`  out  WORD  registered load data, ALU result, PC.
- `writeRegW`  out  REG_SIZE  registered destination.
- `regWriteW`, `mem2regW`, `memWriteW`, `finishW`, `validW`  out  1  registered control bits.
- `PCSrcM`  out  1  branch taken: zeroM & branchM & validM (combinational).
- `stallM`  out  1  combinational; hold fetch, decode, execute and the M inputs.
- `misalignW`  out  1  registered misalign flag; exists only when `MEM_MISALIGN_TRAP_EN` is defined.

## Operation
- An access is `validM & (memWriteM | mem2regM)`.
- Word index is `ALUResultM[DMEM_POWER+1:2]`. Higher address bits are ignored, so addresses wrap modulo memory size.
- Byte lane is `ALUResultM[1:0]`. Half lane is `ALUResultM[1]`.
- Store: byte-enable merge, so only the addressed byte or half is written. Written exactly once per access, on the completing cycle.
- Load: selected lane is extended to WORD bits per `memSignedM`. Example: byte 0x80 gives 0xFFFFFF80 signed, 0x00000080 unsigned.
- FSM has two states, IDLE and WAIT, with a 4-bit counter `cnt`.
- IDLE:
  - Access with LATENCY>0: go to WAIT, cnt←1, stallM=1.
  - Otherwise: complete this cycle.
- WAIT:
  - stallM=1 while cnt<LATENCY, and cnt increments each cycle.
  - When cnt==LATENCY: stallM=0, the access completes, cnt←0, go to IDLE.
- While stallM=1, the M/W register captures a bubble: validW, regWriteW, memWriteW, finishW all 0; other fields don't-care and driven 0.
- Upstream holds every M input stable while stallM=1. Changing them mid-access is undefined.
- A non-access instruction (validM=1, no memory op) never stalls and passes through in one cycle.
- Back-to-back accesses: each one incurs its full latency. The FSM returns to IDLE for one cycle between accesses, and that cycle is the first stall cycle of the next access.
- RAM contents are not reset.

## Timing
- Access presented in cycle t:
  - stallM is high in cycles t..t+LATENCY-1.
  - RAM write and W capture happen at the rising edge ending cycle t+LATENCY.
  - W outputs are valid in cycle t+LATENCY+1.
- LATENCY=0: identical to a single-cycle stage; stallM is constantly 0.
- RAM read is asynchronous. Read data is sampled on the completing cycle.
- Reset low, at any time:
  - All W outputs go to 0 immediately, along with misalignW.
  - FSM goes to IDLE, cnt←0, stallM→0.
  - An in-flight store is aborted and never committed.
- After reset deasserts, the first edge can capture normally.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠00.
  - A misaligned access does not stall and does not write memory.
  - W captures readDataW=0 and regWriteW=0, with validW kept at 1 and misalignW=1.
- Undefined:
  - No check is made and the misalignW port is absent.
  - Low address bits are forced to alignment: half ignores bit 0, word ignores bits [1:0].

## Structure
- Package `mem_pkg` holds:
  - `mem_size_t` enum: MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10.
  - `mem_state_t` enum: IDLE, WAIT.
  - Constants for the lane-select and extension widths.
- Sub-module `dmem_bank`:
  - Parameter DMEM_POWER.
  - Word-wide RAM with a 4-bit byte write enable.
  - Synchronous write, asynchronous read.
- The top level holds the FSM, lane steering, extension logic and the M/W register.

## Test plan
- LATENCY=0, store word 0xDEADBEEF at 0x10, then load word from 0x10 → readDataW=0xDEADBEEF one cycle later; stallM never 1.
- Store byte 0xA5 at 0x13, then load signed byte from 0x13 → 0xFFFFFFA5. Load unsigned byte → 0x000000A5. Load word from 0x10 → 0xA5ADBEEF.
- LATENCY=3, load → stallM high for exactly 3 cycles; bubbles (validW=0) for 3 cycles, then validW=1 with correct data.
- LATENCY=3, store to 0x20 with reset asserted in the 2nd stall cycle → after reset, a load from 0x20 returns the old contents; all W outputs are 0 during reset.
- Address 0x20 + (1<<(DMEM_POWER+2)) → aliases 0x20.
- With `MEM_MISALIGN_TRAP_EN`, word store at 0x22 → misalignW=1, memory unchanged, no stall, regWriteW=0.
